// File: rtl/gcd_stein.sv
// gcd_stein: multi-cycle binary (Stein) GCD coprocessor.
// Removes common factors of two first, then reduces the odd parts with
// shifts and subtractions only. Reports a zero-operand flag and the number
// of SHIFT+CAL cycles taken.

module gcd_stein #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] gcd,
   output logic             zero_in,
   output logic [CNT_W-1:0] cycles
);

   localparam int K_W = $clog2(WIDTH + 1);

   localparam logic [K_W-1:0]   K_ONE   = K_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CAL   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [K_W-1:0]   k;
   logic [CNT_W-1:0] cnt;

   // Whole engine: state, datapath registers and registered outputs advance together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ready   <= 1'b1;
         done    <= 1'b0;
         gcd     <= '0;
         zero_in <= 1'b0;
         cycles  <= '0;
         x       <= '0;
         y       <= '0;
         k       <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x       <= a;
                  y       <= b;
                  k       <= '0;
                  cnt     <= '0;
                  gcd     <= '0;
                  zero_in <= 1'b0;
                  ready   <= 1'b0;
                  state   <= SHIFT;
               end
            end

            SHIFT: begin
               if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_ONE;
               end
               if ((x == '0) || (y == '0)) begin
                  gcd     <= x | y;
                  zero_in <= 1'b1;
                  done    <= 1'b1;
                  state   <= DONE;
               end else if (!x[0] && !y[0]) begin
                  x <= x >> 1;
                  y <= y >> 1;
                  k <= k + K_ONE;
               end else begin
                  state <= CAL;
               end
            end

            CAL: begin
               if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_ONE;
               end
               if (x == y) begin
                  gcd   <= x << k;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (!x[0]) begin
                  x <= x >> 1;
               end else if (!y[0]) begin
                  y <= y >> 1;
               end else if (x > y) begin
                  x <= x - y;
               end else begin
                  y <= y - x;
               end
            end

            DONE: begin
               done   <= 1'b0;
               ready  <= 1'b1;
               cycles <= cnt;
               state  <= IDLE;
            end

            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: self-checking bench for gcd_stein (WIDTH=16, CNT_W=8).
// A transaction-level model predicts every output each cycle; directed
// vectors also carry hand-computed results.

module tb_gcd_stein;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        ready;
   logic        done;
   logic [15:0] gcd;
   logic        zero_in;
   logic [7:0]  cycles;

   int testsRun    = 0;
   int testsFailed = 0;
   bit checkEn     = 0;
   int doneSeen    = 0;

   // Model state: remaining busy cycles, pending result, visible outputs.
   int          mRem       = 0;
   bit          mDone      = 0;
   int          mN         = 0;
   logic [15:0] pendG      = '0;
   bit          pendZ      = 0;
   logic [15:0] mGcd       = '0;
   bit          mZero      = 0;
   int          mCycles    = 0;
   int          mCompleted = 0;

   gcd_stein #(.WIDTH(16), .CNT_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .done    (done),
      .gcd     (gcd),
      .zero_in (zero_in),
      .cycles  (cycles)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference GCD by Euclid's remainder method, independent of the binary algorithm.
   function automatic logic [15:0] refGcd(input logic [15:0] p, input logic [15:0] q);
      int u;
      int v;
      int t;
      u = int'(p);
      v = int'(q);
      while (v != 0) begin
         t = u % v;
         u = v;
         v = t;
      end
      return u[15:0];
   endfunction

   // Number of SHIFT+CAL steps the binary method needs for one operand pair.
   function automatic int modelSteps(input logic [15:0] p, input logic [15:0] q);
      int u;
      int v;
      int n;
      if (p == 0 || q == 0) return 1;
      u = int'(p);
      v = int'(q);
      n = 0;
      while ((u % 2 == 0) && (v % 2 == 0)) begin
         u = u / 2;
         v = v / 2;
         n++;
      end
      n++;
      forever begin
         n++;
         if (u == v) break;
         if (u % 2 == 0)      u = u / 2;
         else if (v % 2 == 0) v = v / 2;
         else if (u > v)      u = u - v;
         else                 v = v - u;
      end
      return n;
   endfunction

   // Single comparison point: counts and reports every check.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: advances on each rising edge from the inputs seen there.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            mRem    = 0;
            mDone   = 0;
            mGcd    = '0;
            mZero   = 0;
            mCycles = 0;
         end else if (mDone) begin
            mDone   = 0;
            mCycles = (mN > 255) ? 255 : mN;
         end else if (mRem > 0) begin
            mRem--;
            if (mRem == 0) begin
               mDone = 1;
               mGcd  = pendG;
               mZero = pendZ;
               mCompleted++;
            end
         end else if (start) begin
            mGcd  = '0;
            mZero = 0;
            pendG = refGcd(a, b);
            pendZ = (a == 0) || (b == 0);
            mN    = modelSteps(a, b);
            mRem  = mN;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model, on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (checkEn) begin
            checkOutput("ready",   32'(ready),   32'((mRem == 0) && !mDone));
            checkOutput("done",    32'(done),    32'(mDone));
            checkOutput("gcd",     32'(gcd),     32'(mGcd));
            checkOutput("zero_in", 32'(zero_in), 32'(mZero));
            checkOutput("cycles",  32'(cycles),  32'(mCycles));
            if (done === 1'b1) doneSeen++;
         end
      end
   end

   // Launch one operation from IDLE and wait for its done pulse.
   task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                output int latency, output int readyLow);
      bit seen;
      seen     = 0;
      latency  = 0;
      readyLow = 0;
      start = 1'b1;
      a     = av;
      b     = bv;
      @(posedge clk); #2;
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
      for (int i = 1; i <= 300 && !seen; i++) begin
         @(negedge clk);
         if (!ready) readyLow++;
         if (done) begin
            seen    = 1;
            latency = i;
         end
      end
      if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #2;
   endtask

   // Directed vector with hand-computed gcd, zero flag and cycle count.
   task automatic runDirected(input string name, input logic [15:0] av, input logic [15:0] bv,
                              input int expG, input int expZ, input int expC);
      int lat;
      int rl;
      applyStimulus(av, bv, lat, rl);
      checkOutput({name, "_gcd"},       32'(gcd),     32'(expG));
      checkOutput({name, "_zero_in"},   32'(zero_in), 32'(expZ));
      checkOutput({name, "_cycles"},    32'(cycles),  32'(expC));
      checkOutput({name, "_latency"},   32'(lat),     32'(expC + 1));
      checkOutput({name, "_ready_low"}, 32'(rl),      32'(expC + 1));
   endtask

   // Wait (bounded) until the engine is back in IDLE, then realign to the drive point.
   task automatic waitIdle();
      bit idle;
      idle = 0;
      for (int i = 0; i < 300 && !idle; i++) begin
         @(negedge clk);
         if (ready) idle = 1;
      end
      if (!idle) checkOutput("idle_timeout", 32'd0, 32'd1);
      @(posedge clk); #2;
   endtask

   // Main stimulus sequence.
   initial begin
      int lat;
      int rl;
      logic [15:0] ra;
      logic [15:0] rb;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      @(posedge clk); #2;
      checkEn = 1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset_ready",   32'(ready),   32'd1);
      checkOutput("reset_done",    32'(done),    32'd0);
      checkOutput("reset_gcd",     32'(gcd),     32'd0);
      checkOutput("reset_zero_in", 32'(zero_in), 32'd0);
      checkOutput("reset_cycles",  32'(cycles),  32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #2;

      runDirected("g12_18",   16'd12,    16'd18,    6,     0, 6);
      runDirected("g0_7",     16'd0,     16'd7,     7,     1, 1);
      runDirected("g0_0",     16'd0,     16'd0,     0,     1, 1);
      runDirected("g32768",   16'd32768, 16'd32768, 32768, 0, 17);
      runDirected("g65535_1", 16'd65535, 16'd1,     1,     0, 32);
      runDirected("g21_14",   16'd21,    16'd14,    7,     0, 5);
      runDirected("g48_18",   16'd48,    16'd18,    6,     0, 8);

      // start held high with fresh operands every cycle
      start = 1'b1;
      for (int i = 0; i < 60; i++) begin
         a = 16'($urandom_range(0, 255));
         b = 16'($urandom_range(0, 255));
         @(posedge clk); #2;
      end
      start = 1'b0;
      waitIdle();

      // reset in the middle of CAL aborts the operation
      runDirected("g9_6_pre", 16'd9, 16'd6, 3, 0, 5);
      start = 1'b1;
      a     = 16'd12;
      b     = 16'd18;
      @(posedge clk); #2;
      start = 1'b0;
      @(posedge clk); #2;
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_ready",   32'(ready),   32'd1);
      checkOutput("abort_done",    32'(done),    32'd0);
      checkOutput("abort_gcd",     32'(gcd),     32'd0);
      checkOutput("abort_zero_in", 32'(zero_in), 32'd0);
      checkOutput("abort_cycles",  32'(cycles),  32'd0);
      @(posedge clk); #2;
      runDirected("g9_6", 16'd9, 16'd6, 3, 0, 5);

      // random sweep, back-to-back launches
      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 4 == 1) begin
            ra = ra & 16'h00ff;
            rb = rb & 16'h00ff;
         end
         if (i % 4 == 2) begin
            ra = ra << (i % 9);
            rb = rb << (i % 7);
         end
         if (i % 25 == 3) ra = '0;
         applyStimulus(ra, rb, lat, rl);
      end

      repeat (3) @(posedge clk);
      #2;
      checkOutput("done_count", 32'(doneSeen), 32'(mCompleted));
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
